// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 5;

    // Wide enough for any practical WIDTH; users slice off the low WIDTH bits.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_sub.sv
// WIDTH+1-bit trial subtractor: part_rem - divisor as a ripple of full adders
// (divisor inverted, carry-in 1); borrow is the inverted final carry.
module div_trial_sub #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    logic [WIDTH:0] b_inv;
    logic [WIDTH+1:0] carry;

    assign b_inv    = ~{1'b0, divisor};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign diff[i]    = part_rem[i] ^ b_inv[i] ^ carry[i];
        assign carry[i+1] = (part_rem[i] & b_inv[i]) | (carry[i] & (part_rem[i] ^ b_inv[i]));
    end

    assign borrow = ~carry[WIDTH+1];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

`ifdef DIVIDER_SIGNED_EN
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction
`endif

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // qsh_q shifts dividend bits out at the top while quotient bits enter at the bottom.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             unused_diff_msb;

    assign shifted = {prem_q, qsh_q[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .part_rem (shifted),
        .divisor  (dvs_q),
        .diff     (diff),
        .borrow   (borrow)
    );

    assign unused_diff_msb = diff[WIDTH];
    assign step_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {qsh_q[WIDTH-2:0], ~borrow};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        qsh_d       = qsh_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = DBZ_QUOTIENT[WIDTH-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
`ifdef DIVIDER_SIGNED_EN
                        dvs_d   = mag_of(divisor);
                        qsh_d   = mag_of(dividend);
                        q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_d = dividend[WIDTH-1];
`else
                        dvs_d   = divisor;
                        qsh_d   = dividend;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
`endif
                        prem_d  = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step_rem;
                qsh_d  = step_quo;
                if (cnt_q == LAST_STEP) begin
`ifdef DIVIDER_SIGNED_EN
                    quotient_d  = apply_sign(step_quo, q_neg_q);
                    remainder_d = apply_sign(step_rem, r_neg_q);
`else
                    quotient_d  = step_quo;
                    remainder_d = step_rem;
`endif
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            qsh_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            qsh_q       <= qsh_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH=5), unsigned or DIVIDER_SIGNED_EN build.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;

`ifdef DIVIDER_SIGNED_EN
    // 23 is -9 in two's complement: -9/5 -> q=-1, r=-4; 31 is -1: -1/1 -> q=-1, r=0
    localparam logic [4:0] Q23_5 = 5'h1F;
    localparam logic [4:0] R23_5 = 5'h1C;
    localparam logic [4:0] Q31_1 = 5'h1F;
`else
    localparam logic [4:0] Q23_5 = 5'd4;
    localparam logic [4:0] R23_5 = 5'd3;
    localparam logic [4:0] Q31_1 = 5'd31;
`endif

    restoring_divider #(.WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair, then wait (bounded) for the result; returns with DUT in DONE.
    task automatic start_and_wait(input string tag, input logic [4:0] a, input logic [4:0] b,
                                  input int exp_lat);
        int k;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b ^ 5'h15;
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(k + 1), 32'(exp_lat));
    endtask

    task automatic run_div(input string tag, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] exp_q, input logic [4:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        start_and_wait(tag, a, b, exp_lat);
        chk({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        run_div("d23_5", 5'd23, 5'd5, Q23_5, R23_5, 1'b0, 6);
        run_div("d31_1", 5'd31, 5'd1, Q31_1, 5'd0, 1'b0, 6);
        run_div("d3_7", 5'd3, 5'd7, 5'd0, 5'd3, 1'b0, 6);
        run_div("d0_9", 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 6);
        run_div("d12_0", 5'd12, 5'd0, 5'd31, 5'd12, 1'b1, 1);

        // Backpressure: results held, in_ready low, new in_valid ignored.
        start_and_wait("bp", 5'd23, 5'd5, 6);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            dividend = 5'd1;
            divisor  = 5'd1;
            tick();
            chk("bp_quotient_hold", 32'(quotient), 32'(Q23_5));
            chk("bp_remainder_hold", 32'(remainder), 32'(R23_5));
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_quotient", 32'(quotient), 32'(Q23_5));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bp_no_queued_result", 32'(out_valid), 32'd0);
        end

        // Reset in the third CALC cycle abandons the operation.
        dividend = 5'd23;
        divisor  = 5'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_quotient", 32'(quotient), 32'd0);
        chk("mid_rst_remainder", 32'(remainder), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        end

`ifdef DIVIDER_SIGNED_EN
        run_div("s_m7_2", 5'b11001, 5'd2, 5'b11101, 5'b11111, 1'b0, 6);
        run_div("s_7_m2", 5'd7, 5'b11110, 5'b11101, 5'd1, 1'b0, 6);
        run_div("s_m16_m1", 5'b10000, 5'b11111, 5'b10000, 5'd0, 1'b0, 6);
        run_div("s_m5_0", 5'b11011, 5'd0, 5'b11111, 5'b11011, 1'b1, 1);
`else
        run_div("d30_4", 5'd30, 5'd4, 5'd7, 5'd2, 1'b0, 6);
        run_div("d31_31", 5'd31, 5'd31, 5'd1, 5'd0, 1'b0, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
